// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed seven-segment scanner for NUM_DIGITS digits.
// The hex value is snapshotted once per frame, then decoded with dp, blanking,
// leading-zero suppression, a dark guard interval per slot and PWM brightness.
// All outputs are registered with the selected output polarity applied.
// Note: the reset input is named rst_n but is active-high (1 = reset).
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_COUNT  = 100000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    input  logic                      lz_suppress,
    input  logic [3:0]                brightness,
    output logic [0:6]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     digit,
    output logic                      frame_start
);

    localparam int ST_W  = $clog2(REFRESH_COUNT);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [ST_W-1:0]  SLOT_LAST = ST_W'(REFRESH_COUNT - 1);
    localparam logic [ST_W-1:0]  BLANK_END = ST_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ?
                                                {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [ST_W-1:0]         slot_timer;
    logic [IDX_W-1:0]        digit_idx;
    logic [3:0]              pwm_cnt;

    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic                    sh_lz;

    logic                    at_snap;
    logic                    lit;
    logic                    suppressed;
    logic [3:0]              cur_nib;
    logic [NUM_DIGITS-1:0]   zero_from;
    logic [6:0]              pattern;
    logic [NUM_DIGITS-1:0]   onehot;

    // Hex to lit-segment pattern, bit 6 = a ... bit 0 = g.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] p;
        case (nib)
            4'h0: p = 7'b1111110;
            4'h1: p = 7'b0110000;
            4'h2: p = 7'b1101101;
            4'h3: p = 7'b1111001;
            4'h4: p = 7'b0110011;
            4'h5: p = 7'b1011011;
            4'h6: p = 7'b1011111;
            4'h7: p = 7'b1110000;
            4'h8: p = 7'b1111111;
            4'h9: p = 7'b1111011;
            4'hA: p = 7'b1110111;
            4'hB: p = 7'b0011111;
            4'hC: p = 7'b1001110;
            4'hD: p = 7'b0111101;
            4'hE: p = 7'b1001111;
            default: p = 7'b1000111;
        endcase
        return p;
    endfunction

    assign at_snap = (digit_idx == '0) && (slot_timer == '0);

    // Slot timer, digit index and free-running PWM counter.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            slot_timer <= '0;
            digit_idx  <= '0;
            pwm_cnt    <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            if (slot_timer == SLOT_LAST) begin
                slot_timer <= '0;
                digit_idx  <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
            end else begin
                slot_timer <= slot_timer + 1'b1;
            end
        end
    end

    // Per-frame snapshot of the display data so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            sh_lz     <= 1'b0;
        end else if (at_snap) begin
            sh_digits <= digits_in;
            sh_dp     <= dp_in;
            sh_blank  <= blank_in;
            sh_lz     <= lz_suppress;
        end
    end

    // zero_from[i]: shadow nibbles NUM_DIGITS-1 down to i are all zero.
    always_comb begin
        zero_from = '0;
        zero_from[NUM_DIGITS-1] = (sh_digits[4*(NUM_DIGITS-1) +: 4] == 4'h0);
        for (int unsigned j = 1; j < NUM_DIGITS; j++) begin
            zero_from[NUM_DIGITS-1-j] = zero_from[NUM_DIGITS-j] &&
                                        (sh_digits[4*(NUM_DIGITS-1-j) +: 4] == 4'h0);
        end
    end

    // Current-digit decode, lit qualification and one-hot enable.
    always_comb begin
        cur_nib    = sh_digits[{digit_idx, 2'b00} +: 4];
        suppressed = sh_lz && (digit_idx != '0) && zero_from[digit_idx];
        lit        = (slot_timer >= BLANK_END) && (pwm_cnt <= brightness) &&
                     !sh_blank[digit_idx];
        pattern    = suppressed ? 7'b0000000 : hex_decode(cur_nib);
        onehot     = '0;
        if (lit) begin
            onehot = NUM_DIGITS'(1) << digit_idx;
        end
    end

    // Output register with polarity applied.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            seg         <= SEG_OFF;
            dp          <= DP_OFF;
            digit       <= DIG_OFF;
            frame_start <= 1'b0;
        end else begin
            seg         <= lit ? (pattern ^ SEG_OFF) : SEG_OFF;
            dp          <= lit ? (sh_dp[digit_idx] ^ DP_OFF) : DP_OFF;
            digit       <= onehot ^ DIG_OFF;
            frame_start <= at_snap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized self-checking bench for seg7_scan_ctrl. Three instances with
// different geometry/polarity are compared every cycle against a model that
// derives all counter state arithmetically from the cycle count since reset.
module tb_seg7_scan_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] digits_in;
    logic [7:0]  dp_in;
    logic [7:0]  blank_in;
    logic        lz;
    logic [3:0]  br;

    logic [0:6] a_seg, b_seg, c_seg;
    logic       a_dp, b_dp, c_dp;
    logic [3:0] a_dig;
    logic [2:0] b_dig;
    logic [4:0] c_dig;
    logic       a_fs, b_fs, c_fs;

    int checks = 0;
    int failures = 0;

    seg7_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_COUNT(8), .BLANK_CYCLES(2),
                     .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) u_a (
        .clk(clk), .rst_n(rst), .digits_in(digits_in[15:0]), .dp_in(dp_in[3:0]),
        .blank_in(blank_in[3:0]), .lz_suppress(lz), .brightness(br),
        .seg(a_seg), .dp(a_dp), .digit(a_dig), .frame_start(a_fs));

    seg7_scan_ctrl #(.NUM_DIGITS(3), .REFRESH_COUNT(40), .BLANK_CYCLES(2),
                     .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) u_b (
        .clk(clk), .rst_n(rst), .digits_in(digits_in[11:0]), .dp_in(dp_in[2:0]),
        .blank_in(blank_in[2:0]), .lz_suppress(lz), .brightness(br),
        .seg(b_seg), .dp(b_dp), .digit(b_dig), .frame_start(b_fs));

    seg7_scan_ctrl #(.NUM_DIGITS(5), .REFRESH_COUNT(6), .BLANK_CYCLES(1),
                     .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) u_c (
        .clk(clk), .rst_n(rst), .digits_in(digits_in[19:0]), .dp_in(dp_in[4:0]),
        .blank_in(blank_in[4:0]), .lz_suppress(lz), .brightness(br),
        .seg(c_seg), .dp(c_dp), .digit(c_dig), .frame_start(c_fs));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Lit segments per hex value, written as segment letters.
    string seg_tbl [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    // Mask with bit 6 = a ... bit 0 = g (matches seg[0:6] read as a vector).
    function automatic logic [6:0] seg_mask(input logic [3:0] n);
        string s;
        logic [6:0] m;
        s = seg_tbl[n];
        m = '0;
        for (int i = 0; i < s.len(); i++) m[6 - (int'(s[i]) - 97)] = 1'b1;
        return m;
    endfunction

    task automatic model_step(input int nn, input int rr, input int bb, input bit sl, input bit dl,
                              input bit rs, input int kk, input logic [31:0] sd,
                              input logic [7:0] sdp, input logic [7:0] sbl, input bit slz,
                              input logic [3:0] b, output logic [6:0] oseg, output logic odp,
                              output logic [7:0] odig, output logic ofs);
        int slot, idx, pwm;
        bit lit, supp;
        logic [6:0] m;
        logic pdp;
        logic [7:0] oh, nmask;
        nmask = 8'((16'd1 << nn) - 16'd1);
        m = '0; pdp = 1'b0; oh = '0; ofs = 1'b0;
        if (!rs) begin
            slot = kk % rr;
            idx  = (kk / rr) % nn;
            pwm  = kk % 16;
            ofs  = ((kk % (nn * rr)) == 0);
            lit  = (slot >= bb) && (pwm <= int'(b)) && !sbl[idx];
            if (lit) begin
                supp = slz && (idx != 0) && ((sd >> (4 * idx)) == 32'd0);
                m    = supp ? 7'd0 : seg_mask(4'(sd >> (4 * idx)));
                pdp  = sdp[idx];
                oh   = 8'(1 << idx);
            end
        end
        oseg = sl ? ~m : m;
        odp  = sl ? ~pdp : pdp;
        odig = dl ? (~oh & nmask) : oh;
    endtask

    int          k     [3];
    logic [31:0] sh_d  [3];
    logic [7:0]  sh_dp [3];
    logic [7:0]  sh_bl [3];
    bit          sh_lz [3];
    logic [6:0]  e_seg [3];
    logic        e_dp  [3];
    logic [7:0]  e_dig [3];
    logic        e_fs  [3];
    bit          have_exp = 0;
    int nn, rr, bb;
    bit sl, dl;

    // Reference model: expected outputs for this edge, then state advance.
    always @(posedge clk) begin
        for (int j = 0; j < 3; j++) begin
            case (j)
                0: begin nn = 4; rr = 8;  bb = 2; sl = 1; dl = 1; end
                1: begin nn = 3; rr = 40; bb = 2; sl = 1; dl = 1; end
                default: begin nn = 5; rr = 6; bb = 1; sl = 0; dl = 0; end
            endcase
            model_step(nn, rr, bb, sl, dl, rst, k[j], sh_d[j], sh_dp[j], sh_bl[j], sh_lz[j], br,
                       e_seg[j], e_dp[j], e_dig[j], e_fs[j]);
            if (rst) begin
                k[j] = 0; sh_d[j] = '0; sh_dp[j] = '0; sh_bl[j] = '0; sh_lz[j] = 0;
            end else begin
                if ((k[j] % (nn * rr)) == 0) begin
                    sh_d[j]  = digits_in & 32'((64'd1 << (4 * nn)) - 64'd1);
                    sh_dp[j] = dp_in & 8'((16'd1 << nn) - 16'd1);
                    sh_bl[j] = blank_in & 8'((16'd1 << nn) - 16'd1);
                    sh_lz[j] = lz;
                end
                k[j]++;
            end
        end
        have_exp = 1;
    end

    // Compare registered outputs half a cycle after the active edge.
    always @(negedge clk) begin
        if (have_exp) begin
            check_eq("a_seg", 32'(a_seg), 32'(e_seg[0]));
            check_eq("a_dp",  32'(a_dp),  32'(e_dp[0]));
            check_eq("a_dig", 32'(a_dig), 32'(e_dig[0]));
            check_eq("a_fs",  32'(a_fs),  32'(e_fs[0]));
            check_eq("b_seg", 32'(b_seg), 32'(e_seg[1]));
            check_eq("b_dp",  32'(b_dp),  32'(e_dp[1]));
            check_eq("b_dig", 32'(b_dig), 32'(e_dig[1]));
            check_eq("b_fs",  32'(b_fs),  32'(e_fs[1]));
            check_eq("c_seg", 32'(c_seg), 32'(e_seg[2]));
            check_eq("c_dp",  32'(c_dp),  32'(e_dp[2]));
            check_eq("c_dig", 32'(c_dig), 32'(e_dig[2]));
            check_eq("c_fs",  32'(c_fs),  32'(e_fs[2]));
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_inputs(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b,
                              input logic l, input logic [3:0] bri);
        digits_in = d; dp_in = p; blank_in = b; lz = l; br = bri;
    endtask

    initial begin
        rst = 1'b1;
        set_inputs($urandom, 8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_inputs($urandom, 8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
        end
        @(negedge clk);
        rst = 1'b0;
        set_inputs(32'h0001_1234, 8'h00, 8'h00, 1'b0, 4'd15);
        run(70);
        set_inputs(32'h0000_00AF, 8'h02, 8'h00, 1'b0, 4'd15);
        run(70);
        set_inputs(32'h0000_0070, 8'h00, 8'h00, 1'b1, 4'd15);
        run(70);
        set_inputs(32'h0000_0000, 8'h00, 8'h00, 1'b1, 4'd15);
        run(70);
        set_inputs(32'h0001_1111, 8'h00, 8'h00, 1'b0, 4'd15);
        run(20);
        digits_in = 32'h0002_2222;
        run(53);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        set_inputs($urandom, 8'($urandom), 8'h00, 1'b0, 4'd3);
        run(260);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) digits_in = $urandom & 32'h000F_F00F;
            if ($urandom_range(0, 3) == 0) dp_in = 8'($urandom);
            if ($urandom_range(0, 5) == 0) blank_in = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 7) == 0) lz = 1'($urandom);
            if ($urandom_range(0, 3) == 0) br = 4'($urandom);
            rst = ($urandom_range(0, 149) == 0);
            run(1);
        end
        rst = 1'b0;
        run(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
